// File: rtl/mbist_march_gen.sv
// ---------------------------------------------------------------------------
// mbist_march_gen
// March C- operation sequencer for the memory BIST datapath. While enabled it
// issues one memory operation per cycle and flags the last operation of the
// test so the BIST controller can leave test mode.
//
// Elements (each over every address):
//   E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 up r0
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   ld      in   synchronous clear from the controller, dominates en
//   en      in   advance enable (controller NbarT)
//   addr    out  address of the current operation
//   rwbar   out  1 = read, 0 = write
//   data    out  write data, or expected read data when rwbar = 1
//   mem_en  out  current operation is valid this cycle
//   elem    out  current march element, 6 = done
//   cout    out  current valid operation is the last of the test
//   done    out  sequence complete, held until ld or rst
// ---------------------------------------------------------------------------
module mbist_march_gen #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld,
   input  logic              en,
   output logic [ADDR_W-1:0] addr,
   output logic              rwbar,
   output logic [DATA_W-1:0] data,
   output logic              mem_en,
   output logic [2:0]        elem,
   output logic              cout,
   output logic              done
);

   typedef enum logic [2:0] {
      E0     = 3'd0,
      E1     = 3'd1,
      E2     = 3'd2,
      E3     = 3'd3,
      E4     = 3'd4,
      E5     = 3'd5,
      E_DONE = 3'd6
   } elem_t;

   localparam logic [ADDR_W-1:0] ADDR_LO  = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_HI  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   elem_t             elem_r, elem_s;
   logic [ADDR_W-1:0] addr_r, addr_s;
   logic              op_r, op_s;
   logic              mem_en_s;
   logic              rw_s;
   logic              dbit_s;

   // E3 and E4 walk the address space downwards
   function automatic logic is_down(input elem_t e);
      logic r;
      case (e)
         E3, E4:  r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // Index of the final operation inside an element (single-op elements end at 0)
   function automatic logic last_op(input elem_t e);
      logic r;
      case (e)
         E0, E5:  r = 1'b0;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   // Element sequencing; anything past E5 (or an illegal code) lands in done
   function automatic elem_t next_elem(input elem_t e);
      elem_t r;
      case (e)
         E0:      r = E1;
         E1:      r = E2;
         E2:      r = E3;
         E3:      r = E4;
         E4:      r = E5;
         default: r = E_DONE;
      endcase
      return r;
   endfunction

   // Returns {rwbar, background bit} for (element, op)
   function automatic logic [1:0] decode_op(input elem_t e, input logic op);
      logic [1:0] r;
      case (e)
         E0:      r = 2'b00;          // w0
         E1, E3:  r = {~op, op};      // r0 then w1
         E2, E4:  r = {~op, ~op};     // r1 then w0
         E5:      r = 2'b10;          // r0
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   assign mem_en_s = en & ~ld & (elem_r != E_DONE);

   // Operation decode from the current state
   always_comb begin
      rw_s   = 1'b0;
      dbit_s = 1'b0;
      {rw_s, dbit_s} = decode_op(elem_r, op_r);
   end

   // Next-state: ld clears, otherwise advance op -> address -> element on a valid op
   always_comb begin
      elem_s = elem_r;
      addr_s = addr_r;
      op_s   = op_r;
      if (ld) begin
         elem_s = E0;
         addr_s = ADDR_LO;
         op_s   = 1'b0;
      end else if (mem_en_s) begin
         if (op_r != last_op(elem_r)) begin
            op_s = ~op_r;
         end else if (addr_r != (is_down(elem_r) ? ADDR_LO : ADDR_HI)) begin
            op_s = 1'b0;
            if (is_down(elem_r)) begin
               addr_s = addr_r - ADDR_ONE;
            end else begin
               addr_s = addr_r + ADDR_ONE;
            end
         end else begin
            // Element boundary: reload the start address of the next element
            op_s   = 1'b0;
            elem_s = next_elem(elem_r);
            addr_s = is_down(elem_s) ? ADDR_HI : ADDR_LO;
         end
      end else begin
         elem_s = elem_r;
         addr_s = addr_r;
         op_s   = op_r;
      end
   end

   // State register with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elem_r <= E0;
         addr_r <= ADDR_LO;
         op_r   <= 1'b0;
      end else begin
         elem_r <= elem_s;
         addr_r <= addr_s;
         op_r   <= op_s;
      end
   end

   assign addr   = addr_r;
   assign elem   = elem_r;
   assign rwbar  = rw_s;
   assign data   = {DATA_W{dbit_s}};
   assign mem_en = mem_en_s;
   assign cout   = mem_en_s & (elem_r == E5) & (addr_r == ADDR_HI);
   assign done   = (elem_r == E_DONE);

endmodule

// File: tb/tb_mbist_march_gen.sv
// ---------------------------------------------------------------------------
// tb_mbist_march_gen
// Self-checking bench for mbist_march_gen with ADDR_W=2, DATA_W=4 (N=4, 40 ops).
// A reference op list is built from the March C- element table; expected ops
// are queued as enabled cycles are driven and popped when mem_en is seen.
// ---------------------------------------------------------------------------
module tb_mbist_march_gen;
   localparam int AW   = 2;
   localparam int DW   = 4;
   localparam int N    = 4;
   localparam int NOPS = 10 * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld;
   logic          en;
   logic [AW-1:0] addr;
   logic          rwbar;
   logic [DW-1:0] data;
   logic          mem_en;
   logic [2:0]    elem;
   logic          cout;
   logic          done;

   mbist_march_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk    (clk),
      .rst    (rst),
      .ld     (ld),
      .en     (en),
      .addr   (addr),
      .rwbar  (rwbar),
      .data   (data),
      .mem_en (mem_en),
      .elem   (elem),
      .cout   (cout),
      .done   (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            el;
      int            ad;
      logic          rw;
      logic [DW-1:0] d;
      logic          co;
   } op_t;

   typedef struct {
      logic          l;
      logic          e;
      int            el;
      int            ad;
      logic          rw;
      logic [DW-1:0] d;
      logic          me;
      logic          co;
      logic          dn;
   } vec_t;

   op_t         ref_ops[NOPS];
   op_t         sb_q[$];
   logic [31:0] trace_q[$];
   logic [31:0] trace_a[$];
   int          total = 0;
   int          bad   = 0;
   int          mdl_k = 0;
   int          cout_cnt = 0;
   logic        last_cout = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Reference March C- op list from the element table
   task automatic build_ref();
      int   dir [6] = '{0, 0, 0, 1, 1, 0};
      int   nops[6] = '{1, 2, 2, 2, 2, 1};
      logic d0  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic d1  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int   k = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            for (int o = 0; o < nops[e]; o++) begin
               logic b;
               b = (o == 0) ? d0[e] : d1[e];
               ref_ops[k].el = e;
               ref_ops[k].ad = (dir[e] == 1) ? (N - 1 - i) : i;
               ref_ops[k].rw = (e == 0) ? 1'b0 : ((e == 5) ? 1'b1 : (o == 0));
               ref_ops[k].d  = {DW{b}};
               ref_ops[k].co = (k == NOPS - 1);
               k++;
            end
         end
      end
   endtask

   // One scoreboarded cycle: inputs applied at posedge+1, outputs checked at negedge
   task automatic run_cycle(input logic l, input logic e);
      logic exp_mem;
      logic exp_done;
      op_t  o;
      ld = l;
      en = e;
      exp_done = (mdl_k == NOPS);
      exp_mem  = 1'b0;
      if (!l && e && mdl_k < NOPS) begin
         sb_q.push_back(ref_ops[mdl_k]);
         exp_mem = 1'b1;
      end
      @(negedge clk);
      chk("mem_en", mem_en, exp_mem);
      chk("done", done, exp_done);
      last_cout = cout;
      if (cout) cout_cnt++;
      if (mem_en) begin
         trace_q.push_back({21'd0, elem, addr, rwbar, data, cout});
         if (sb_q.size() == 0) begin
            flag("sb_empty");
         end else begin
            o = sb_q.pop_front();
            chk("op_elem", elem, o.el);
            chk("op_addr", addr, o.ad);
            chk("op_rwbar", rwbar, o.rw);
            chk("op_data", data, o.d);
            chk("op_cout", cout, o.co);
         end
      end else begin
         chk("cout_idle", cout, 1'b0);
      end
      sb_q.delete();
      if (l) mdl_k = 0;
      else if (exp_mem) mdl_k++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      int g = 0;
      while (mdl_k < target && g < 200) begin
         run_cycle(1'b0, 1'b1);
         g++;
      end
      if (mdl_k < target) flag("run_to");
   endtask

   initial begin
      vec_t vt[7];
      int   g;
      logic stalled;

      build_ref();
      rst = 1'b1;
      ld  = 1'b0;
      en  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      chk("rst_elem", elem, 3'd0);
      chk("rst_addr", addr, 2'd0);
      chk("rst_rwbar", rwbar, 1'b0);
      chk("rst_data", data, 4'h0);
      chk("rst_done", done, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      en = 1'b1;
      #1;
      chk("mem_en_follows_en", mem_en, 1'b1);
      en = 1'b0;
      #1;

      // Table-driven directed vectors from the reset state
      vt[0] = '{1'b1, 1'b0, 0, 0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 1'b1, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 0, 1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
      vt[3] = '{1'b0, 1'b0, 0, 2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b1, 1'b1, 0, 2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 0, 0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0};
      vt[6] = '{1'b0, 1'b0, 0, 1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         ld = vt[i].l;
         en = vt[i].e;
         @(negedge clk);
         chk("vec_elem", elem, vt[i].el);
         chk("vec_addr", addr, vt[i].ad);
         chk("vec_rwbar", rwbar, vt[i].rw);
         chk("vec_data", data, vt[i].d);
         chk("vec_mem_en", mem_en, vt[i].me);
         chk("vec_cout", cout, vt[i].co);
         chk("vec_done", done, vt[i].dn);
         @(posedge clk);
         #1;
      end

      // Full sequence with a 3-cycle stall at E2 addr 1 op 1
      cout_cnt = 0;
      run_cycle(1'b1, 1'b0);
      stalled = 1'b0;
      g = 0;
      while (mdl_k < NOPS && g < 200) begin
         if (mdl_k == 15 && !stalled) begin
            stalled = 1'b1;
            for (int s = 0; s < 3; s++) begin
               ld = 1'b0;
               en = 1'b0;
               @(negedge clk);
               chk("stall_elem", elem, 3'd2);
               chk("stall_addr", addr, 2'd1);
               chk("stall_rwbar", rwbar, 1'b0);
               chk("stall_data", data, 4'h0);
               chk("stall_mem_en", mem_en, 1'b0);
               chk("stall_cout", cout, 1'b0);
               @(posedge clk);
               #1;
            end
         end
         run_cycle(1'b0, 1'b1);
         g++;
      end
      if (mdl_k < NOPS) flag("full_seq");
      chk("cout_count", cout_cnt, 1);

      // Done hold with en high, then reload
      for (int i = 0; i < 5; i++) begin
         run_cycle(1'b0, 1'b1);
         chk("hold_elem", elem, 3'd6);
      end
      run_cycle(1'b1, 1'b0);
      chk("reload_elem", elem, 3'd0);
      chk("reload_addr", addr, 2'd0);
      chk("reload_done", done, 1'b0);

      // ld and en together in mid-E4
      run_to(30);
      chk("prio_pre_elem", elem, 3'd4);
      run_cycle(1'b1, 1'b1);
      chk("prio_elem", elem, 3'd0);
      chk("prio_addr", addr, 2'd0);

      // Asynchronous reset mid-test at E3 addr 2
      run_to(22);
      ld = 1'b0;
      en = 1'b0;
      chk("pre_rst_elem", elem, 3'd3);
      chk("pre_rst_addr", addr, 2'd2);
      chk("pre_rst_rwbar", rwbar, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_elem", elem, 3'd0);
      chk("arst_addr", addr, 2'd0);
      chk("arst_rwbar", rwbar, 1'b0);
      chk("arst_data", data, 4'h0);
      chk("arst_done", done, 1'b0);
      #1;
      rst = 1'b0;
      mdl_k = 0;
      @(posedge clk);
      #1;

      // Closed loop: start -> ld one cycle -> en until cout -> idle; twice
      for (int r = 0; r < 2; r++) begin
         trace_q.delete();
         cout_cnt = 0;
         run_cycle(1'b1, 1'b0);
         g = 0;
         last_cout = 1'b0;
         while (!last_cout && g < 200) begin
            run_cycle(1'b0, 1'b1);
            g++;
         end
         if (!last_cout) flag("loop_cout");
         run_cycle(1'b0, 1'b0);
         chk("loop_ops", trace_q.size(), NOPS);
         chk("loop_cout_cnt", cout_cnt, 1);
         if (r == 0) begin
            trace_a = trace_q;
         end else begin
            for (int i = 0; i < NOPS; i++) begin
               if (i < trace_q.size() && i < trace_a.size()) begin
                  chk("loop_trace", trace_q[i], trace_a[i]);
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mbist_march_gen.md
# mbist_march_gen

March C- pattern generator for the memory BIST path. It sits directly downstream of the BIST controller. The controller's `ld` output drives `ld` here and its `NbarT` output drives `en`. This block's `cout` feeds back as the controller's `cout` input. While enabled, it issues one memory operation per cycle (address, read/write, data/expected data) to the memory mux and comparator, and flags the final operation.

## Interface
- `ADDR_W`, 10: memory address width; N = 2^ADDR_W words.
- `DATA_W`, 8: memory data width; background patterns are all-zeros / all-ones of this width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high. Forces the initial state.
- `ld`  in  1  synchronous load/clear from the controller. Has priority over `en`.
- `en`  in  1  advance enable (controller test mode, NbarT).
- `addr`  out  ADDR_W  address of the current operation.
- `rwbar`  out  1  1 = read, 0 = write.
- `data`  out  DATA_W  write data when `rwbar`=0; expected read data when `rwbar`=1.
- `mem_en`  out  1  current operation is valid this cycle.
- `elem`  out  3  current march element, 0..5; 6 = done.
- `cout`  out  1  current valid operation is the last of the test.
- `done`  out  1  sequence complete; sticky until `ld` or `rst`.

## Operation
- State registers: `elem` (3 bits), `addr` (ADDR_W bits), `op` (1 bit, operation index within the element at the current address).
- Elements, each applied to every address in the stated direction:
  - E0 up: w0
  - E1 up: r0, w1
  - E2 up: r1, w0
  - E3 down: r0, w1
  - E4 down: r1, w0
  - E5 up: r0
- Data mapping: "0" is {DATA_W{1'b0}} and "1" is {DATA_W{1'b1}}. `rwbar` and `data` are decoded combinationally from (`elem`, `op`).
- `mem_en` = `en` & ~`ld` & (`elem` != 6).
- `cout` = `mem_en` & (`elem`==5) & (`addr`=={ADDR_W{1'b1}}).
- `done` = (`elem`==6).
- Advance, on an edge where `mem_en`=1:
  - If `op` is not the element's last operation: `op` increments.
  - Otherwise, if `addr` is not the element's end address (all-ones for up, 0 for down): `op`←0 and `addr` steps ±1.
  - Otherwise: `op`←0, `elem`+1, and `addr`←start address of the next element (0 for up, all-ones for down). From E5, `elem`←6 and `addr`←0.
- `ld`=1 at an edge: `elem`←0, `addr`←0, `op`←0, regardless of `en` or current state.
- `en`=0 with `ld`=0: all state holds. Outputs keep decoding the held state, but `mem_en` and `cout` are 0.
- `elem`=6: state holds until `ld`. `en` is ignored and `mem_en`=0.

## Timing
- Reset values: `elem`=0, `addr`=0, `op`=0. Therefore `rwbar`=0, `data`=0, `done`=0, and `mem_en`/`cout` follow `en`/`ld` combinationally (0 while `en`=0).
- One operation per enabled cycle, zero latency. Outputs are valid in the same cycle as the state that produces them.
- Total valid operations: 10·N. The first issues in the first cycle with `en`=1 after `ld` drops; `cout` is high exactly on the 10·N-th.
- Handshake: `cout` is high for one cycle. At that edge the controller leaves test mode and this block enters `elem`=6. The controller then asserts `ld`, which returns this block to E0 on the following edge.
- `rst` asserted mid-test: state clears immediately, asynchronously, with no wait for `clk`. Deassertion takes effect from the next edge.
- `ld` and `en` both high: `ld` wins, and `mem_en`=0 for that cycle.
- Address wrap: up elements never increment past all-ones, and down elements never decrement below 0. Element transitions reload the address explicitly.

## Test plan
- Reset: `rst` pulse at a mid-cycle instant with `elem`=3 and `addr`=5 → `elem`=0, `addr`=0, `rwbar`=0, `data`=0, `done`=0 before the next edge.
- Full sequence with ADDR_W=2 and DATA_W=4, `ld` for 1 cycle then `en` held high → 40 `mem_en` cycles:
  - E0: w0 at addresses 0,1,2,3.
  - E1: r0,w1 pairs at 0..3.
  - E2: r1,w0 pairs at 0..3.
  - E3: r0,w1 pairs at 3..0.
  - E4: r1,w0 pairs at 3..0.
  - E5: r0 at 0..3.
  - `data` is 4'h0 or 4'hF per the element table.
  - `cout`=1 only on cycle 40 (addr 3, read); `done`=1 from cycle 41.
- Stall: drop `en` for 3 cycles at E2, `addr`=1, `op`=1 → state and `addr`/`rwbar`/`data` hold, `mem_en`=0, `cout`=0. Resume continues with w0 at address 1.
- Done hold and reload: after `done`=1, keep `en`=1 for 5 cycles → no change, `mem_en`=0. Then `ld`=1 → next edge gives `elem`=0, `addr`=0, `done`=0.
- Priority: `ld`=1 and `en`=1 together in mid-E4 → `mem_en`=0 that cycle and state clears to E0/addr 0.
- Closed loop with the controller: `start` pulse → exactly 10·N memory operations, controller returns to its idle state one cycle after `cout`, and this block is reloaded by `ld`. A second `start` repeats an identical trace.
